// File: rtl/wired_regslice_pkg.sv
// rtl/wired_regslice_pkg.sv - shared mode encoding and occupancy limits for wired_regslice
package wired_regslice_pkg;

  typedef enum logic [1:0] {
    SLICE_BYPASS,
    SLICE_FWD,
    SLICE_BWD,
    SLICE_FULL
  } slice_mode_e;

  localparam int unsigned SLICE_MAX_OCC = 2;

  // Largest occupancy each mode can ever report.
  function automatic logic [1:0] mode_max_occ(input slice_mode_e mode);
    return (mode == SLICE_FULL)   ? 2'(SLICE_MAX_OCC) :
           (mode == SLICE_BYPASS) ? 2'd0 : 2'd1;
  endfunction

endpackage

// File: rtl/wired_regslice_fifo2.sv
// rtl/wired_regslice_fifo2.sv - two-entry circular buffer; ready and valid come from the count register only
module wired_regslice_fifo2
  import wired_regslice_pkg::*;
#(
  parameter type T = logic [31:0]
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push_valid,
  output logic       push_ready,
  input  T           push_payload,
  output logic       pop_valid,
  input  logic       pop_ready,
  output T           pop_payload,
  output logic [1:0] count
);

  localparam logic [1:0] FULL_COUNT = 2'(SLICE_MAX_OCC);

  T     mem [2];
  logic wr_ptr;
  logic rd_ptr;
  logic push;
  logic pop;

  assign push_ready  = (count != FULL_COUNT);
  assign pop_valid   = (count != 2'd0);
  assign pop_payload = mem[rd_ptr];
  assign push        = push_valid & push_ready;
  assign pop         = pop_valid & pop_ready;

  // 1-bit pointers wrap on their own; push+pop together leaves count untouched.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_payload;
  end

endmodule

// File: rtl/wired_regslice.sv
// rtl/wired_regslice.sv - valid/ready register slice; MODE picks which paths are cut
// Flush gates both handshake directions at this level so every mode behaves alike.
module wired_regslice
  import wired_regslice_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         T          = logic [DATA_WIDTH-1:0],
  parameter slice_mode_e MODE       = SLICE_FULL
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       inport_valid,
  output logic       inport_ready,
  input  T           inport_payload,
  output logic       outport_valid,
  input  logic       outport_ready,
  output T           outport_payload,
  output logic [1:0] occupancy
);

  logic in_valid;
  logic out_ready;
  logic core_valid;
  logic core_ready;

  assign in_valid      = inport_valid & ~flush;
  assign out_ready     = outport_ready & ~flush;
  assign inport_ready  = core_ready & ~flush;
  assign outport_valid = core_valid & ~flush;

  generate
    if (MODE == SLICE_BYPASS) begin : g_bypass
      assign core_valid      = in_valid;
      assign core_ready      = out_ready;
      assign outport_payload = inport_payload;
      assign occupancy       = 2'd0;
    end else if (MODE == SLICE_FWD) begin : g_fwd
      logic full;
      T     data;
      logic push;

      assign core_ready      = ~full | out_ready;
      assign core_valid      = full;
      assign outport_payload = data;
      assign occupancy       = {1'b0, full};
      assign push            = in_valid & core_ready;

      // A push while full and draining simply overwrites the departing beat.
      always_ff @(posedge clk) begin
        if (!rst_n || flush) full <= 1'b0;
        else if (push)       full <= 1'b1;
        else if (out_ready)  full <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (push) data <= inport_payload;
      end
    end else if (MODE == SLICE_BWD) begin : g_bwd
      logic skid_full;
      T     skid_data;
      logic capture;

      assign core_ready      = ~skid_full;
      assign core_valid      = skid_full | in_valid;
      assign outport_payload = skid_full ? skid_data : inport_payload;
      assign occupancy       = {1'b0, skid_full};
      assign capture         = in_valid & ~skid_full & ~out_ready;

      always_ff @(posedge clk) begin
        if (!rst_n || flush) skid_full <= 1'b0;
        else if (capture)    skid_full <= 1'b1;
        else if (out_ready)  skid_full <= 1'b0;
      end

      always_ff @(posedge clk) begin
        if (capture) skid_data <= inport_payload;
      end
    end else begin : g_full
      wired_regslice_fifo2 #(
        .T(T)
      ) u_fifo2 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .push_valid   (in_valid),
        .push_ready   (core_ready),
        .push_payload (inport_payload),
        .pop_valid    (core_valid),
        .pop_ready    (out_ready),
        .pop_payload  (outport_payload),
        .count        (occupancy)
      );
    end
  endgenerate

  localparam logic [1:0] MAX_OCC = mode_max_occ(MODE);

  a_out_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (outport_valid && !outport_ready) |=> (flush || (outport_valid && $stable(outport_payload))));

  a_occ_max : assert property (@(posedge clk) disable iff (!rst_n) occupancy <= MAX_OCC);

endmodule
